pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines the load-use hazard flag from `Hazard_detect`, the EX-stage branch-redirect flag and the data-memory handshake into per-stage write-enable and flush controls. It also tracks data-memory wait time with a timeout that halts the pipeline, and keeps saturating performance counters for stall cycles and branch flushes.

## Interface
- MAX_WAIT, 16, consecutive data-memory freeze cycles allowed before halting; legal range 2..255.
- CNT_W, 16, width of the performance counters.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- LU_hazard  in  1  load-use hazard from `Hazard_detect`.
- Branch_taken_EX  in  1  branch/jump in EX redirects the PC this cycle.
- Dmem_req  in  1  MEM stage is issuing a data-memory access.
- Dmem_ready  in  1  data memory completes the access this cycle; ignored when Dmem_req=0.
- PC_write  out  1  PC register load enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- ID_EX_write  out  1  ID/EX register load enable.
- ID_EX_flush  out  1  load a bubble (control bits zero) into ID/EX.
- EX_MEM_write  out  1  EX/MEM register load enable.
- MEM_WB_flush  out  1  load a bubble into MEM/WB.
- Mem_timeout  out  1  sticky; high while in HALT.
- Stall_cycles  out  CNT_W  count of cycles with PC_write=0, excluding HALT; saturating.
- Flush_count  out  CNT_W  count of branch flushes; saturating.

## Operation
- States: RUN, MEM_WAIT, HALT. A register `wait_cnt` (8 bits) counts consecutive freeze cycles.
- Outputs are combinational (Mealy) from state and inputs, so a stall or flush takes effect in the cycle the condition is present.
- `mem_stall = Dmem_req & ~Dmem_ready`.
- Evaluation in RUN, and in MEM_WAIT once `mem_stall=0`, is priority-ordered:
  - **mem_stall (freeze):** all `*_write=0`, `MEM_WB_flush=1`, other flushes 0. Branch and load-use are deferred; they re-present because the upstream stages are frozen.
  - **Branch_taken_EX:** `PC_write=1`, `IF_ID_write=1`, `IF_ID_flush=1`, `ID_EX_write=1`, `ID_EX_flush=1`, `EX_MEM_write=1`. Branch overrides LU_hazard, because the dependent instruction is flushed anyway.
  - **LU_hazard:** `PC_write=0`, `IF_ID_write=0`, `ID_EX_write=1`, `ID_EX_flush=1`, `EX_MEM_write=1`, `MEM_WB_flush=0`.
  - **Otherwise:** all `*_write=1`, all flushes 0.
- Transitions:
  - RUN with mem_stall: next state MEM_WAIT, `wait_cnt<=1`.
  - MEM_WAIT with mem_stall: freeze. If `wait_cnt==MAX_WAIT-1`, go to HALT; else `wait_cnt<=wait_cnt+1`.
  - MEM_WAIT with `mem_stall=0`: normal priority evaluation this cycle; next state RUN, `wait_cnt<=0`.
  - HALT: all `*_write=0`, `MEM_WB_flush=1`, other flushes 0, `Mem_timeout=1`. Only rst exits HALT, even if Dmem_ready later rises.
- Counters:
  - Stall_cycles increments in every non-HALT cycle with `PC_write=0`, i.e. freeze or load-use stall.
  - Flush_count increments in every cycle where the branch row is taken.
  - Both hold at 2^CNT_W-1 (saturate, no wrap).
- Dmem_req dropping during MEM_WAIT counts as `mem_stall=0` and releases the freeze.

## Timing
- Reset values:
  - Registers: state=RUN, `wait_cnt=0`, `Mem_timeout=0`, Stall_cycles=0, Flush_count=0.
  - Combinational outputs during any cycle with `rst=1`: all `*_write=1`, all flushes 0.
  - Counters do not increment on a cycle with `rst=1`.
  - Reset in MEM_WAIT or HALT returns to RUN on the next edge.
- Stall/flush latency is 0 cycles (same cycle as input). State, counter and Mem_timeout updates are visible 1 cycle later.
- A single load-use stall costs exactly 1 cycle, provided LU_hazard deasserts after the ID_EX bubble.
- Freeze timing: HALT is entered on the edge ending the MAX_WAIT-th consecutive freeze cycle (the first counted cycle is the RUN cycle). If Dmem_ready rises in freeze cycle MAX_WAIT, the access completes and there is no halt.
- Simultaneous events:
  - mem_stall + branch + LU: freeze only; Flush_count unchanged.
  - branch + LU: branch row; Stall_cycles unchanged.

## Test plan
- **Reset:** rst=1 for 2 cycles with LU_hazard=1 and Dmem_req=1 -> PC_write=1, all flushes 0. After release, counters=0 and Mem_timeout=0.
- **Load-use:** LU_hazard=1 for 1 cycle in RUN -> that cycle PC_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1. Next cycle all writes=1, Stall_cycles=1.
- **Branch vs LU:** Branch_taken_EX=1 and LU_hazard=1 together -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1. Flush_count=1, Stall_cycles=0.
- **Memory wait:** MAX_WAIT=16, Dmem_req=1, Dmem_ready=0 for 3 cycles then 1 -> 3 cycles all writes=0 and MEM_WB_flush=1. 4th cycle normal with state back to RUN, Stall_cycles=3, Mem_timeout=0.
- **Timeout:** MAX_WAIT=4, Dmem_ready held 0 -> Mem_timeout=1 from cycle 5. Dmem_ready=1 afterwards keeps HALT. rst clears to RUN.
- **Saturation:** CNT_W=4, 20 load-use stalls -> Stall_cycles holds at 15. Boundary case: Dmem_ready=1 exactly in freeze cycle 4 with MAX_WAIT=4 -> no HALT.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch redirect and
// data-memory handshake into per-stage enables, with a memory timeout and perf counters.
module pipeline_stall_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LU_hazard,
  input  logic             Branch_taken_EX,
  input  logic             Dmem_req,
  input  logic             Dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] Stall_cycles,
  output logic [CNT_W-1:0] Flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  typedef enum logic [1:0] {ROW_NORMAL, ROW_FREEZE, ROW_BRANCH, ROW_LU} row_t;

  localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  row_t       row;
  logic       mem_stall;

  assign mem_stall = Dmem_req & ~Dmem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // NOTE: defaults first in every combinational block keep unassigned paths from
  // inferring latches.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // Priority select of the control row; reset forces the pass-through row.
  always_comb begin
    row = ROW_NORMAL;
    if (rst)                             row = ROW_NORMAL;
    else if (state == HALT || mem_stall) row = ROW_FREEZE;
    else if (Branch_taken_EX)            row = ROW_BRANCH;
    else if (LU_hazard)                  row = ROW_LU;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    unique case (row)
      ROW_FREEZE: begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_flush = 1'b1;
      end
      ROW_BRANCH: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      ROW_LU: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign Mem_timeout = (state == HALT);

  // HALT cycles are excluded so the stall count reflects recoverable stalls only.
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_cycles <= '0;
      Flush_count  <= '0;
    end else begin
      if (state != HALT && !PC_write && Stall_cycles != CNT_MAX)
        Stall_cycles <= Stall_cycles + 1'b1;
      if (row == ROW_BRANCH && Flush_count != CNT_MAX)
        Flush_count <= Flush_count + 1'b1;
    end
  end

endmodule
